fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch front end that drives the instruction memory. It generates the next fetch address every cycle. The memory registers that address on the clock edge and returns the word one cycle later. fetch_unit pairs each returned word with its PC and hands it to decode with a valid flag. It also handles pipeline stall, branch/jump redirect, and misaligned-target trapping. It sits between the pipeline control (stall/redirect sources) and the 64 KiB word-addressed imem.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC fetched first after reset; must be word-aligned
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- imem_addr  out  32  next fetch address, combinational; imem latches it each posedge
- imem_rd_data  in  32  word at the address latched on the previous edge
- stall  in  1  decode cannot accept; hold current output
- redirect  in  1  taken branch/jump; discard current output
- redirect_pc  in  32  redirect target
- if_pc  out  32  PC of if_insn
- if_insn  out  32  instruction to decode; NOP 32'h0000_0013 whenever if_valid=0
- if_valid  out  1  if_insn/if_pc are a live instruction
- if_misaligned  out  1  fetch halted on a redirect target with [1:0]!=0; if_pc holds that target

## Operation
- Registers:
  - pc_q (32): address whose data is on imem_rd_data this cycle.
  - state (2 bits): FILL, RUN, HALT.
- Reset, while rst_n=0:
  - state<=FILL, pc_q<=RESET_VECTOR.
  - imem_addr=RESET_VECTOR.
  - Outputs: if_valid=0, if_misaligned=0, if_pc=RESET_VECTOR, if_insn=NOP.
- Outputs:
  - if_pc=pc_q.
  - if_valid=(state==RUN) && !redirect.
  - if_insn=if_valid ? imem_rd_data : NOP.
  - if_misaligned=(state==HALT).
- "Aligned" means redirect_pc[1:0]==0. Redirect has priority over stall in every state.
- FILL:
  - imem_addr=pc_q; next state RUN with pc_q unchanged.
  - Aligned redirect: imem_addr=redirect_pc, pc_q<=redirect_pc, next RUN.
  - Misaligned redirect: pc_q<=redirect_pc, next HALT.
- RUN:
  - Aligned redirect: imem_addr=redirect_pc, pc_q<=redirect_pc, stay RUN.
  - Misaligned redirect: imem_addr=pc_q, pc_q<=redirect_pc, next HALT.
  - Stall (no redirect): imem_addr=pc_q, pc_q held. imem re-reads the same word, so if_insn is stable.
  - Otherwise: imem_addr=pc_q+4, pc_q<=pc_q+4.
- HALT:
  - imem_addr=pc_q; stall ignored.
  - Aligned redirect: exit as in RUN, next RUN.
  - Misaligned redirect: pc_q<=redirect_pc, stay HALT.
- Arithmetic: pc_q+4 is 32-bit modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). imem uses only addr[15:2], so fetch past 0xFFFC aliases to word 0 by design.
- Misaligned RESET_VECTOR is a configuration error; not checked in RTL.

## Timing
- Fetch latency: address presented in cycle n, word and if_valid=1 in cycle n+1.
- First live instruction is the second cycle after rst_n rises (one FILL bubble).
- Redirect cost: output in the redirect cycle is killed (NOP, valid=0). Target word is live the next cycle; no further bubble.
- Stall: outputs hold exactly while stall=1. The instruction after the stalled one appears one cycle after stall falls.
- Simultaneous stall+redirect: redirect wins; the stalled instruction is discarded.
- Combinational paths:
  - redirect/redirect_pc/stall -> imem_addr.
  - redirect -> if_valid/if_insn.
- rst_n low mid-operation: next edge forces FILL and RESET_VECTOR regardless of stall/redirect.

## Structure
- define.vh gains:
  - RESET_VECTOR default.
  - NOP constant 32'h0000_0013.
  - FILL/RUN/HALT state encodings.
- Single module; the next-address mux stays inline. No sub-module is warranted.

## Test plan
- Reset release, RESET_VECTOR=0, imem word k = 0x1000_0000+k:
  - if_valid 0 for one cycle after rst_n rises.
  - Then (if_pc, if_insn) = (0, 0x1000_0000), (4, 0x1000_0001), (8, …) on consecutive cycles.
- Stall for 3 cycles while if_pc=0x8:
  - if_pc=0x8 and if_insn=0x1000_0002 held for all 3 cycles.
  - imem_addr=0x8 throughout; next cycle if_pc=0xC.
- Redirect to 0x40 while if_pc=0x10:
  - That cycle if_valid=0, if_insn=NOP, imem_addr=0x40.
  - Next cycle if_pc=0x40, if_insn=0x1000_0010, valid=1.
- Redirect to 0x42 with stall=1:
  - Next cycle if_misaligned=1, if_pc=0x42, if_valid=0.
  - A later redirect to 0x80 gives if_pc=0x80 valid one cycle after it, with if_misaligned cleared.
- Free-run across 0xFFFC:
  - if_pc sequence 0xFFFC, 0x1_0000.
  - imem_addr[15:2] wraps to 0; if_insn=0x1000_0000.
- rst_n pulled low for one cycle mid-stream with stall=1 and redirect=1:
  - During the reset cycle imem_addr=RESET_VECTOR, if_valid=0, if_misaligned=0.
  - Then the standard FILL sequence from RESET_VECTOR.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants for the instruction-fetch front end
package fetch_unit_pkg;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] HALT = 2'd2;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: next-address generation, PC/word pairing, stall, redirect and misaligned-target halt
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_pc,
  output logic [31:0] if_insn,
  output logic        if_valid,
  output logic        if_misaligned
);
  logic [1:0] state, state_d;
  logic [31:0] pc_q, pc_d;
  logic aligned;
  // next fetch address is also the next pc, except when a misaligned target parks the pc
  always_comb begin
    aligned = redirect_pc[1:0] == 2'b00;
    imem_addr = !rst_n ? RESET_VECTOR
              : (redirect && aligned) ? redirect_pc
              : (state == RUN && !redirect && !stall) ? pc_q + 32'd4
              : pc_q;
    pc_d = (redirect && !aligned) ? redirect_pc : imem_addr;
    state_d = redirect ? (aligned ? RUN : HALT) : (state == HALT ? HALT : RUN);
    if_valid = rst_n && state == RUN && !redirect;
    if_misaligned = rst_n && state == HALT;
    if_pc = rst_n ? pc_q : RESET_VECTOR;
    if_insn = if_valid ? imem_rd_data : NOP;
  end
  // pc tracks the address whose word is on imem_rd_data this cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
      pc_q <= RESET_VECTOR;
    end else begin
      state <= state_d;
      pc_q <= pc_d;
    end
  end
endmodule
